// File: rtl/seq_detector_pkg.sv
// ============================================================================
//  Module   : seq_detector_pkg
//  Purpose  : Shared state encoding and constants for the 1011 Moore detector.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_detector_pkg;

  // Present-state codes; the numeric values are visible on the prs_st port.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S1   = 3'd1,
    S10  = 3'd2,
    S101 = 3'd3,
    DET  = 3'd4
  } state_t;

  // Serial pattern recognised by the detector, first-received bit on the left.
  localparam logic [3:0] PATTERN = 4'b1011;

  // Width of the optional match counter.
  localparam int CNT_W = 8;

endpackage : seq_detector_pkg

`default_nettype wire

// File: rtl/seq_detector_moore.sv
// ============================================================================
//  Module   : seq_detector_moore
//  Purpose  : Non-overlapping Moore detector for serial pattern 1011.
//             detected is decoded from the state register only, so it is
//             high for exactly one cycle after the final '1' is sampled.
//             Optional feature macro SEQDET_COUNT_EN adds match_cnt, an
//             8-bit saturating count of DET entries.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detector_moore
  import seq_detector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       detected,
  output logic [2:0] prs_st
`ifdef SEQDET_COUNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  // State register is a plain 3-bit vector so the illegal codes 5..7 can be
  // named and recovered explicitly.
  localparam logic [2:0] ST_IDLE = IDLE;
  localparam logic [2:0] ST_S1   = S1;
  localparam logic [2:0] ST_S10  = S10;
  localparam logic [2:0] ST_S101 = S101;
  localparam logic [2:0] ST_DET  = DET;

  logic [2:0] state_q;
  logic [2:0] state_d;

  // Next-state logic; DET restarts from scratch so matches never overlap.
  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: state_d = in ? ST_S1   : ST_IDLE;
      ST_S1:   state_d = in ? ST_S1   : ST_S10;
      ST_S10:  state_d = in ? ST_S101 : ST_IDLE;
      ST_S101: state_d = in ? ST_DET  : ST_S10;
      ST_DET:  state_d = in ? ST_S1   : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset taking priority over the data bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign prs_st   = state_q;
  assign detected = (state_q == ST_DET);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count entries into DET, holding at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d == ST_DET) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule : seq_detector_moore

`default_nettype wire

// File: tb/tb_seq_detector_moore.sv
// ============================================================================
//  Module   : tb_seq_detector_moore
//  Purpose  : Scoreboard bench for seq_detector_moore. The driver pushes the
//             expected post-edge state for every bit it applies; a monitor
//             pops and compares after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_detector_moore;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in  = 1'b0;
  logic       detected;
  logic [2:0] prs_st;
`ifdef SEQDET_COUNT_EN
  logic [7:0] match_cnt;
`endif

  seq_detector_moore dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .detected (detected),
    .prs_st   (prs_st)
`ifdef SEQDET_COUNT_EN
    ,
    .match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       det;
    logic [7:0] cnt;
    string      name;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;
  int   exp_cnt = 0;

  // Apply one bit before the next rising edge and record what must follow it.
  task automatic step(input logic r, input logic b, input logic [2:0] st,
                      input string name);
    exp_t e;
    @(negedge clk);
    rst = r;
    in  = b;
    if (r) exp_cnt = 0;
    else if (st == 3'd4 && exp_cnt < 255) exp_cnt = exp_cnt + 1;
    e.st   = st;
    e.det  = (st == 3'd4);
    e.cnt  = exp_cnt[7:0];
    e.name = name;
    q.push_back(e);
  endtask

  // Monitor: one expected entry is consumed per rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (prs_st !== e.st) begin
          failed++;
          $display("FAIL %s prs_st: got %0d expected %0d", e.name, prs_st, e.st);
        end
        tests++;
        if (detected !== e.det) begin
          failed++;
          $display("FAIL %s detected: got %0b expected %0b", e.name, detected, e.det);
        end
`ifdef SEQDET_COUNT_EN
        tests++;
        if (match_cnt !== e.cnt) begin
          failed++;
          $display("FAIL %s match_cnt: got %0d expected %0d", e.name, match_cnt, e.cnt);
        end
`endif
      end
    end
  end

  // Stream 1101_0110_1011_0101 and the states the transition table gives.
  logic [15:0] s_bits = 16'b1101_0110_1011_0101;
  logic [2:0]  s_st [16] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd2, 3'd3, 3'd4, 3'd0,
                             3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [6:0]  n_bits = 7'b1011011;
  logic [2:0]  n_st [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1};
  logic [7:0]  p_bits = 8'b1100_1011;
  logic [2:0]  p_st [8] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
  logic [3:0]  pat = 4'b1011;
  logic [2:0]  pat_st [4] = '{3'd1, 3'd2, 3'd3, 3'd4};

  initial begin
    int guard;
    // Reset held for two edges while in toggles, then released.
    step(1'b1, 1'b1, 3'd0, "reset0");
    step(1'b1, 1'b0, 3'd0, "reset1");
    step(1'b0, 1'b0, 3'd0, "post_reset");

    for (int i = 0; i < 16; i++) step(1'b0, s_bits[15-i], s_st[i], "stream");

    step(1'b1, 1'b0, 3'd0, "reset_a");
    for (int i = 0; i < 7; i++) step(1'b0, n_bits[6-i], n_st[i], "nonoverlap");

    step(1'b1, 1'b0, 3'd0, "reset_b");
    for (int i = 0; i < 8; i++) step(1'b0, p_bits[7-i], p_st[i], "prefix");

    step(1'b1, 1'b0, 3'd0, "reset_c");
    step(1'b0, 1'b1, 3'd1, "midrst_1");
    step(1'b0, 1'b0, 3'd2, "midrst_2");
    step(1'b0, 1'b1, 3'd3, "midrst_3");
    step(1'b1, 1'b1, 3'd0, "midrst_rst");
    step(1'b0, 1'b1, 3'd1, "midrst_final");

    // Back-to-back patterns: 70 matches, then enough to saturate the counter.
    step(1'b1, 1'b0, 3'd0, "reset_d");
    for (int k = 0; k < 70; k++)
      for (int i = 0; i < 4; i++) step(1'b0, pat[3-i], pat_st[i], "rep70");
    step(1'b1, 1'b0, 3'd0, "reset_e");
    for (int k = 0; k < 300; k++)
      for (int i = 0; i < 4; i++) step(1'b0, pat[3-i], pat_st[i], "rep300");
    step(1'b1, 1'b0, 3'd0, "reset_final");
    step(1'b0, 1'b0, 3'd0, "idle_final");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    #2;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_seq_detector_moore

`default_nettype wire
